carfield_domain_rst_seq: RTL and testbench

// - Per-domain reset sequencer for the Carfield reset domains: Periph, Safed, Secd, IntCluster, FPCluster, L2 (indices 0..5).
// - Sits downstream of the Carfield register file, which raises SW reset request pulses.
// - Drives the AXI isolation of each domain and that domain's active-low reset.
// - Ordering: isolate and drain AXI, hold reset, release, de-isolate. No domain is reset with a transaction in flight, unless the drain timeout expires.

---
 rtl/carfield_domain_rst_seq.sv | 167 ++++++++++++++++
 tb/tb_carfield_domain_rst_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_domain_rst_seq.sv
// carfield_domain_rst_seq
// Per-domain reset sequencer for the Carfield reset domains
// (Periph, Safed, Secd, IntCluster, FPCluster, L2).
// Each domain runs its own sequence: isolate and drain AXI, hold the domain
// reset, release it while still isolated, then de-isolate.
// Optional feature: define CARFIELD_RST_SEQ_MASK_EN to add rst_mask_i, which
// lets software block new reset requests per domain.
module carfield_domain_rst_seq #(
    parameter int unsigned NumDomains    = 6,
    parameter int unsigned DrainTimeout  = 1024,
    parameter int unsigned RstHoldCycles = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumDomains-1:0] rst_req_i,
    input  logic [NumDomains-1:0] isolated_i,
    input  logic [NumDomains-1:0] clr_timeout_i,
`ifdef CARFIELD_RST_SEQ_MASK_EN
    input  logic [NumDomains-1:0] rst_mask_i,
`endif
    output logic [NumDomains-1:0] isolate_o,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic [NumDomains-1:0] busy_o,
    output logic [NumDomains-1:0] done_o,
    output logic [NumDomains-1:0] timeout_o
);

    localparam int unsigned MaxCount = (DrainTimeout > RstHoldCycles) ? DrainTimeout : RstHoldCycles;
    localparam int unsigned CntWidth = $clog2(MaxCount + 1);

    localparam logic [CntWidth-1:0] DrainLoad = CntWidth'(DrainTimeout);
    localparam logic [CntWidth-1:0] HoldLoad  = CntWidth'(RstHoldCycles);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

    typedef enum logic [2:0] {
        StIdle,
        StIso,
        StRst,
        StRel,
        StDeiso
    } SeqState;

    // Requests that are allowed to start or queue a sequence.
    logic [NumDomains-1:0] reqEff;

`ifdef CARFIELD_RST_SEQ_MASK_EN
    assign reqEff = rst_req_i & ~rst_mask_i;
`else
    assign reqEff = rst_req_i;
`endif

    for (genvar d = 0; d < NumDomains; d++) begin : gDomain
        SeqState             stateQ, stateD;
        logic [CntWidth-1:0] cntQ, cntD;
        logic                pendQ, pendD;
        logic                isoQ, isoD;
        logic                rstNQ, rstND;
        logic                busyQ, busyD;
        logic                doneQ, doneD;
        logic                toQ, toD;
        logic                toSet;

        // Next-state and registered-output computation for one domain.
        // The counter expiring is detected at value 1 so that the transition
        // edge is exactly the load value number of cycles after entry.
        always_comb begin
            stateD = stateQ;
            cntD   = cntQ;
            pendD  = pendQ;
            isoD   = isoQ;
            rstND  = rstNQ;
            doneD  = 1'b0;
            toSet  = 1'b0;

            if (stateQ != StIdle && reqEff[d]) begin
                pendD = 1'b1;
            end

            case (stateQ)
                StIdle: begin
                    if (reqEff[d] || pendQ) begin
                        stateD = StIso;
                        isoD   = 1'b1;
                        cntD   = DrainLoad;
                        pendD  = 1'b0;
                    end
                end
                StIso: begin
                    if (isolated_i[d]) begin
                        stateD = StRst;
                        rstND  = 1'b0;
                        cntD   = HoldLoad;
                    end else if (cntQ <= CntOne) begin
                        stateD = StRst;
                        rstND  = 1'b0;
                        cntD   = HoldLoad;
                        toSet  = 1'b1;
                    end else begin
                        cntD = cntQ - CntOne;
                    end
                end
                StRst: begin
                    if (cntQ <= CntOne) begin
                        stateD = StRel;
                        rstND  = 1'b1;
                    end else begin
                        cntD = cntQ - CntOne;
                    end
                end
                StRel: begin
                    stateD = StDeiso;
                    isoD   = 1'b0;
                    cntD   = DrainLoad;
                end
                StDeiso: begin
                    if (!isolated_i[d]) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end else if (cntQ <= CntOne) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                        toSet  = 1'b1;
                    end else begin
                        cntD = cntQ - CntOne;
                    end
                end
                default: begin
                    stateD = StIdle;
                end
            endcase

            busyD = (stateD != StIdle);
            toD   = (toQ & ~clr_timeout_i[d]) | toSet;
        end

        // State, counter and output registers; reset parks the domain in
        // reset so the power-on release runs through the normal sequence.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stateQ <= StRst;
                cntQ   <= HoldLoad;
                pendQ  <= 1'b0;
                isoQ   <= 1'b1;
                rstNQ  <= 1'b0;
                busyQ  <= 1'b1;
                doneQ  <= 1'b0;
                toQ    <= 1'b0;
            end else begin
                stateQ <= stateD;
                cntQ   <= cntD;
                pendQ  <= pendD;
                isoQ   <= isoD;
                rstNQ  <= rstND;
                busyQ  <= busyD;
                doneQ  <= doneD;
                toQ    <= toD;
            end
        end

        assign isolate_o[d]     = isoQ;
        assign domain_rst_no[d] = rstNQ;
        assign busy_o[d]        = busyQ;
        assign done_o[d]        = doneQ;
        assign timeout_o[d]     = toQ;
    end

endmodule

// File: tb/tb_carfield_domain_rst_seq.sv
// tb_carfield_domain_rst_seq
// Self-checking bench: randomized requests and ack latencies, expected
// waveforms computed from sequence timing arithmetic per domain.
module tb_carfield_domain_rst_seq;

    localparam int ND     = 6;
    localparam int DT     = 64;
    localparam int RH     = 8;
    localparam int WIN    = 320;
    localparam int MAXLAG = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [ND-1:0] req;
    logic [ND-1:0] isolated;
    logic [ND-1:0] clr;
    logic [ND-1:0] maskV;
    logic [ND-1:0] iso;
    logic [ND-1:0] rstN;
    logic [ND-1:0] busy;
    logic [ND-1:0] done;
    logic [ND-1:0] to;

    int checks   = 0;
    int failures = 0;

    int            lag   [ND];
    bit            stuck [ND];
    logic [ND-1:0] hist  [MAXLAG+1];
    logic [ND-1:0] toState;

    logic [ND-1:0]   reqAt   [WIN];
    logic [ND-1:0]   clrAt   [WIN];
    logic [ND-1:0]   expIso  [WIN];
    logic [ND-1:0]   expRstN [WIN];
    logic [ND-1:0]   expBusy [WIN];
    logic [ND-1:0]   expDone [WIN];
    logic [ND-1:0]   expTo   [WIN];
    logic [ND-1:0]   setTo   [WIN];
    logic [5*ND-1:0] expAll  [WIN];
    logic [5*ND-1:0] obsAll  [WIN];

    always #5 clk = ~clk;

    carfield_domain_rst_seq #(
        .NumDomains   (ND),
        .DrainTimeout (DT),
        .RstHoldCycles(RH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rst_req_i    (req),
        .isolated_i   (isolated),
        .clr_timeout_i(clr),
`ifdef CARFIELD_RST_SEQ_MASK_EN
        .rst_mask_i   (maskV),
`endif
        .isolate_o    (iso),
        .domain_rst_no(rstN),
        .busy_o       (busy),
        .done_o       (done),
        .timeout_o    (to)
    );

    // AXI isolate unit stand-in: ack mirrors isolate_o lag cycles later.
    always @(negedge clk) begin
        hist[0] <= iso;
        for (int i = 1; i <= MAXLAG; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        for (int d = 0; d < ND; d++) isolated[d] = stuck[d] ? 1'b0 : hist[lag[d]][d];
    end

    // Paint one sequence starting with isolate_o rising at isoAt (isoAt<0:
    // power-on release at cycle 0); returns the first IDLE cycle.
    function automatic int paintSeq(input int d, input int isoAt, input int n);
        int fall, rise, deiso, idle, lagOff;
        if (isoAt < 0) begin
            fall = 0;
        end else if (stuck[d] || lag[d] + 1 > DT) begin
            fall = isoAt + DT;
            if (fall < n) setTo[fall][d] = 1'b1;
        end else begin
            fall = isoAt + lag[d] + 1;
        end
        rise   = fall + RH;
        deiso  = rise + 1;
        lagOff = stuck[d] ? 0 : lag[d];
        if (lagOff + 1 > DT) begin
            idle = deiso + DT;
            if (idle < n) setTo[idle][d] = 1'b1;
        end else begin
            idle = deiso + lagOff + 1;
        end
        for (int k = (isoAt < 0) ? 0 : isoAt; k < idle && k < n; k++) begin
            expBusy[k][d] = 1'b1;
            expIso[k][d]  = (k < deiso);
            expRstN[k][d] = !(k >= fall && k < rise);
        end
        if (idle < n) expDone[idle][d] = 1'b1;
        return idle;
    endfunction

    task automatic buildExpected(input int n, input bit powerOn, input logic [ND-1:0] toInit);
        int free, used, isoAt;
        for (int k = 0; k < n; k++) begin
            expIso[k] = '0; expRstN[k] = '1; expBusy[k] = '0; expDone[k] = '0; setTo[k] = '0;
        end
        for (int d = 0; d < ND; d++) begin
            free = powerOn ? paintSeq(d, -1, n) : 0;
            used = 0;
            for (int c = 0; c < n; c++) begin
                if (reqAt[c][d] && !maskV[d] && c >= used) begin
                    isoAt = (c >= free) ? c + 1 : free + 1;
                    free  = paintSeq(d, isoAt, n);
                    used  = isoAt;
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            if (k == 0) expTo[k] = (powerOn ? '0 : toInit) | setTo[0];
            else        expTo[k] = (expTo[k-1] & ~clrAt[k-1]) | setTo[k];
            expAll[k] = {expIso[k], expRstN[k], expBusy[k], expDone[k], expTo[k]};
        end
    endtask

    task automatic clearStim();
        for (int k = 0; k < WIN; k++) begin
            reqAt[k] = '0;
            clrAt[k] = '0;
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic randomLags();
        for (int d = 0; d < ND; d++) lag[d] = int'($urandom_range(0, MAXLAG));
    endtask

    // Drive the stimulus tables and capture outputs once per cycle.
    task automatic runWindow(input int n, input bit powerOn);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obsAll[k] = {iso, rstN, busy, done, to};
            if (powerOn && k == 0) rst_n = 1'b1;
            req = reqAt[k];
            clr = clrAt[k];
        end
        @(posedge clk);
        #1;
        req = '0;
        clr = '0;
    endtask

    task automatic test_reset();
        logic [5*ND-1:0] rv;
        rv = {{ND{1'b1}}, {ND{1'b0}}, {ND{1'b1}}, {ND{1'b0}}, {ND{1'b0}}};
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({iso, rstN, busy, done, to} !== rv) begin
            failures++;
            $display("FAIL reset_async got %h expected %h", {iso, rstN, busy, done, to}, rv);
        end
        quiet(MAXLAG + 4);
        checks++;
        if ({iso, rstN, busy, done, to} !== rv) begin
            failures++;
            $display("FAIL reset_held got %h expected %h", {iso, rstN, busy, done, to}, rv);
        end
    endtask

    task automatic test_power_on();
        randomLags();
        clearStim();
        buildExpected(60, 1'b1, '0);
        runWindow(60, 1'b1);
        for (int k = 0; k < 60; k++) begin
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL power_on cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        toState = expTo[59];
    endtask

    task automatic test_single_domain3();
        int lowCnt;
        quiet(MAXLAG + 2);
        randomLags();
        lag[3] = 5;
        clearStim();
        reqAt[2][3] = 1'b1;
        buildExpected(40, 1'b0, toState);
        runWindow(40, 1'b0);
        lowCnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (obsAll[k][3*ND+3] === 1'b0) lowCnt++;
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL single_d3 cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        checks++;
        if (lowCnt !== RH) begin
            failures++;
            $display("FAIL single_d3_hold got %0d cycles expected %0d", lowCnt, RH);
        end
        toState = expTo[39];
    endtask

    task automatic test_timeout_d1();
        quiet(MAXLAG + 2);
        randomLags();
        stuck[1] = 1'b1;
        clearStim();
        reqAt[1][1] = 1'b1;
        clrAt[65][1] = 1'b1;
        clrAt[90][1] = 1'b1;
        buildExpected(100, 1'b0, toState);
        runWindow(100, 1'b0);
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL timeout_d1 cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        toState = expTo[99];
        stuck[1] = 1'b0;
    endtask

    task automatic test_pending_d0();
        int fall, doneCnt;
        quiet(MAXLAG + 2);
        randomLags();
        lag[0] = int'($urandom_range(0, 4));
        clearStim();
        reqAt[1][0] = 1'b1;
        fall = 2 + lag[0] + 1;
        reqAt[fall + 2][0] = 1'b1;
        reqAt[fall + 5][0] = 1'b1;
        buildExpected(70, 1'b0, toState);
        runWindow(70, 1'b0);
        doneCnt = 0;
        for (int k = 0; k < 70; k++) begin
            if (obsAll[k][ND] === 1'b1) doneCnt++;
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL pending_d0 cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        checks++;
        if (doneCnt !== 2) begin
            failures++;
            $display("FAIL pending_d0_done got %0d pulses expected 2", doneCnt);
        end
        toState = expTo[69];
    endtask

    task automatic test_random();
        for (int round = 0; round < 2; round++) begin
            quiet(MAXLAG + 2);
            randomLags();
            clearStim();
            for (int k = 0; k < 299; k++) begin
                for (int d = 0; d < ND; d++) begin
                    if (k < 200 && $urandom_range(0, 39) == 0) reqAt[k][d] = 1'b1;
                    if ($urandom_range(0, 49) == 0) clrAt[k][d] = 1'b1;
                end
            end
            if (round == 0) reqAt[1] = '1;
            buildExpected(300, 1'b0, toState);
            runWindow(300, 1'b0);
            for (int k = 0; k < 300; k++) begin
                checks++;
                if (obsAll[k] !== expAll[k]) begin
                    failures++;
                    $display("FAIL random r%0d cycle %0d got %h expected %h", round, k, obsAll[k], expAll[k]);
                end
            end
            toState = expTo[299];
        end
    endtask

    task automatic test_async_reset_d4();
        logic [5*ND-1:0] rv;
        rv = {{ND{1'b1}}, {ND{1'b0}}, {ND{1'b1}}, {ND{1'b0}}, {ND{1'b0}}};
        quiet(MAXLAG + 2);
        randomLags();
        lag[4] = 10;
        clearStim();
        reqAt[1][4] = 1'b1;
        reqAt[4][4] = 1'b1;
        buildExpected(6, 1'b0, toState);
        runWindow(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL async_pre cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({iso, rstN, busy, done, to} !== rv) begin
            failures++;
            $display("FAIL async_reset got %h expected %h", {iso, rstN, busy, done, to}, rv);
        end
        quiet(MAXLAG + 4);
        clearStim();
        buildExpected(60, 1'b1, '0);
        runWindow(60, 1'b1);
        for (int k = 0; k < 60; k++) begin
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL async_rerun cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        toState = expTo[59];
    endtask

`ifdef CARFIELD_RST_SEQ_MASK_EN
    task automatic test_mask();
        quiet(MAXLAG + 2);
        randomLags();
        maskV = 6'b000100;
        clearStim();
        reqAt[1][2] = 1'b1;
        reqAt[1][5] = 1'b1;
        reqAt[7][2] = 1'b1;
        buildExpected(40, 1'b0, toState);
        runWindow(40, 1'b0);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (obsAll[k] !== expAll[k]) begin
                failures++;
                $display("FAIL mask_d2 cycle %0d got %h expected %h", k, obsAll[k], expAll[k]);
            end
        end
        toState = expTo[39];
        maskV = '0;
    endtask
`endif

    initial begin
        req     = '0;
        clr     = '0;
        maskV   = '0;
        toState = '0;
        for (int d = 0; d < ND; d++) begin
            lag[d]   = 0;
            stuck[d] = 1'b0;
        end
        test_reset();
        test_power_on();
        test_single_domain3();
        test_timeout_d1();
        test_pending_d0();
        test_random();
        test_async_reset_d4();
`ifdef CARFIELD_RST_SEQ_MASK_EN
        test_mask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
